tomasulo_regstat: RTL and testbench

Parametrised register-status file for the Tomasulo floating-point datapath: holds architectural register values with a per-register producer tag and busy bit. It serves two source operands per issued instruction as value or tag, renames the destination at issue, and retires results from NCDB common-data-bus ports. It sits between instruction decode and the add/mul reservation stations and replaces the single-port, two-unit register block with a clocked, multi-CDB, flushable design.

---
 rtl/tomasulo_regstat_if.sv | 42 ++++
 rtl/tomasulo_regstat.sv | 145 ++++++++++++++
 tb/tb_tomasulo_regstat.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_regstat_if.sv
// Issue/CDB/operand bundle for the Tomasulo register-status file.
// master = decode/CDB side, slave = tomasulo_regstat.
interface tomasulo_regstat_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned TAGW = 5,
    parameter int unsigned NCDB = 2
);
    localparam int unsigned RIDW = $clog2(NREG);
    localparam int unsigned CNTW = $clog2(NREG + 1);

    logic                   issue_valid;
    logic [RIDW-1:0]        issue_rs1;
    logic [RIDW-1:0]        issue_rs2;
    logic                   issue_rd_we;
    logic [RIDW-1:0]        issue_rd;
    logic [TAGW-1:0]        issue_tag;
    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*TAGW-1:0]   cdb_tag;
    logic [NCDB*XLEN-1:0]   cdb_data;
    logic                   flush;
    logic                   op_valid;
    logic                   op1_rdy;
    logic                   op2_rdy;
    logic [XLEN-1:0]        op1_data;
    logic [XLEN-1:0]        op2_data;
    logic [TAGW-1:0]        op1_tag;
    logic [TAGW-1:0]        op2_tag;
    logic [CNTW-1:0]        busy_cnt;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd_we, issue_rd, issue_tag,
        output cdb_valid, cdb_tag, cdb_data, flush,
        input  op_valid, op1_rdy, op2_rdy, op1_data, op2_data, op1_tag, op2_tag, busy_cnt
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd_we, issue_rd, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data, flush,
        output op_valid, op1_rdy, op2_rdy, op1_data, op2_data, op1_tag, op2_tag, busy_cnt
    );
endinterface

// File: rtl/tomasulo_regstat.sv
// Register-status file: values, producer tags and busy bits with rename, NCDB write-back and flush.
// Define TOMASULO_REGSTAT_BYPASS_EN to fold same-cycle CDB broadcasts into issued operands.
module tomasulo_regstat #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned TAGW       = 5,
    parameter int unsigned NCDB       = 2,
    parameter int unsigned ZERO_REG   = 0,
    parameter int unsigned INIT_INDEX = 1
) (
    input  logic                clk,
    input  logic                rst,
    tomasulo_regstat_if.slave   bus
);
    localparam int unsigned RIDW = $clog2(NREG);
    localparam int unsigned CNTW = $clog2(NREG + 1);

    typedef struct packed {
        logic            rdy;
        logic [XLEN-1:0] data;
        logic [TAGW-1:0] tag;
    } operand_t;

    logic [XLEN-1:0] value_q [NREG];
    logic [XLEN-1:0] value_d [NREG];
    logic [TAGW-1:0] tag_q   [NREG];
    logic [TAGW-1:0] tag_d   [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [CNTW-1:0] cnt_d;
    logic [CNTW-1:0] ncomp;
    logic            hit;
    logic [XLEN-1:0] hit_data;
    logic            issue_acc_c;
    logic            rd_zero_c;
    logic            rename_en_c;
    logic [RIDW-1:0] src_id [2];
    operand_t        opnd_c [2];

    assign issue_acc_c = bus.issue_valid & ~bus.flush;
    assign rd_zero_c   = (ZERO_REG != 0) && (bus.issue_rd == '0);
    assign rename_en_c = issue_acc_c & bus.issue_rd_we & ~rd_zero_c;
    assign src_id[0]   = bus.issue_rs1;
    assign src_id[1]   = bus.issue_rs2;

    // Source lookup against pre-update state, so a source equal to rd sees the old mapping
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            opnd_c[s].rdy  = 1'b1;
            opnd_c[s].data = '0;
            opnd_c[s].tag  = '1;
            if ((ZERO_REG != 0) && (src_id[s] == '0)) begin
                opnd_c[s].rdy = 1'b1;
            end else if (busy_q[src_id[s]]) begin
                opnd_c[s].rdy = 1'b0;
                opnd_c[s].tag = tag_q[src_id[s]];
`ifdef TOMASULO_REGSTAT_BYPASS_EN
                for (int k = NCDB - 1; k >= 0; k--) begin
                    if (bus.cdb_valid[k] && (bus.cdb_tag[k*TAGW +: TAGW] == tag_q[src_id[s]])) begin
                        opnd_c[s].rdy  = 1'b1;
                        opnd_c[s].data = bus.cdb_data[k*XLEN +: XLEN];
                        opnd_c[s].tag  = '1;
                    end
                end
`endif
            end else begin
                opnd_c[s].data = value_q[src_id[s]];
            end
        end
    end

    // Per-register update: rename beats completion, flush clears busy but keeps CDB values
    always_comb begin
        value_d  = value_q;
        tag_d    = tag_q;
        busy_d   = busy_q;
        ncomp    = '0;
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < NREG; i++) begin
            hit      = 1'b0;
            hit_data = '0;
            for (int k = NCDB - 1; k >= 0; k--) begin
                if (busy_q[i] && bus.cdb_valid[k] && (bus.cdb_tag[k*TAGW +: TAGW] == tag_q[i])) begin
                    hit      = 1'b1;
                    hit_data = bus.cdb_data[k*XLEN +: XLEN];
                end
            end
            if (rename_en_c && (bus.issue_rd == RIDW'(i))) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.issue_tag;
            end else if (hit) begin
                value_d[i] = hit_data;
                busy_d[i]  = 1'b0;
                tag_d[i]   = '1;
                ncomp      = ncomp + CNTW'(1);
            end
            if (bus.flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '1;
            end
        end
        cnt_d = bus.flush ? '0
              : bus.busy_cnt + CNTW'(rename_en_c && !busy_q[bus.issue_rd]) - ncomp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
                tag_q[i]   <= '1;
            end
            busy_q       <= '0;
            bus.busy_cnt <= '0;
        end else begin
            value_q      <= value_d;
            tag_q        <= tag_d;
            busy_q       <= busy_d;
            bus.busy_cnt <= cnt_d;
        end
    end

    // Operand register: fields hold between issues, op_valid pulses once per accepted issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.op_valid <= 1'b0;
            bus.op1_rdy  <= 1'b1;
            bus.op2_rdy  <= 1'b1;
            bus.op1_data <= '0;
            bus.op2_data <= '0;
            bus.op1_tag  <= '1;
            bus.op2_tag  <= '1;
        end else begin
            bus.op_valid <= issue_acc_c;
            if (issue_acc_c) begin
                bus.op1_rdy  <= opnd_c[0].rdy;
                bus.op2_rdy  <= opnd_c[1].rdy;
                bus.op1_data <= opnd_c[0].data;
                bus.op2_data <= opnd_c[1].data;
                bus.op1_tag  <= opnd_c[0].tag;
                bus.op2_tag  <= opnd_c[1].tag;
            end
        end
    end
endmodule

// File: tb/tb_tomasulo_regstat.sv
// Directed bench for tomasulo_regstat (default parameters, INIT_INDEX=1, ZERO_REG=0).
module tb_tomasulo_regstat;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned TAGW = 5;
    localparam int unsigned NCDB = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tomasulo_regstat_if #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .NCDB(NCDB)) bus ();

    tomasulo_regstat #(
        .XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .NCDB(NCDB), .ZERO_REG(0), .INIT_INDEX(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.issue_rd_we = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_tag   = '0;
        bus.cdb_valid   = '0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input int rs1, input int rs2, input bit we, input int rd, input int tag);
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = 5'(rs1);
        bus.issue_rs2   = 5'(rs2);
        bus.issue_rd_we = we;
        bus.issue_rd    = 5'(rd);
        bus.issue_tag   = 5'(tag);
    endtask

    task automatic drive_cdb(input int port, input int tag, input logic [31:0] data);
        bus.cdb_valid[port]             = 1'b1;
        bus.cdb_tag[port*TAGW +: TAGW]  = 5'(tag);
        bus.cdb_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %0h want 0", bus.op_valid); end
        checks++; if (bus.op1_rdy !== 1'b1 || bus.op2_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0h/%0h want 1/1", bus.op1_rdy, bus.op2_rdy); end
        checks++; if (bus.op1_data !== 32'h0 || bus.op1_tag !== 5'h1f) begin errors++; $display("FAIL reset_op1: got data %0h tag %0h want 0/1f", bus.op1_data, bus.op1_tag); end
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt: got %0d want 0", bus.busy_cnt); end
        rst = 1'b0;
        drive_issue(3, 11, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL init_read_valid: got %0h want 1", bus.op_valid); end
        checks++; if (bus.op1_data !== 32'd3 || bus.op2_data !== 32'd11) begin errors++; $display("FAIL init_read_data: got %0h/%0h want 3/b", bus.op1_data, bus.op2_data); end
        checks++; if (bus.op1_rdy !== 1'b1 || bus.op2_rdy !== 1'b1 || bus.op1_tag !== 5'h1f) begin errors++; $display("FAIL init_read_rdy: got %0h/%0h tag %0h want 1/1/1f", bus.op1_rdy, bus.op2_rdy, bus.op1_tag); end
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL init_read_cnt: got %0d want 0", bus.busy_cnt); end
        cycle();
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL op_valid_pulse: got %0h want 0", bus.op_valid); end
    endtask

    task automatic test_rename_cdb();
        drive_issue(0, 0, 1'b1, 5, 7);
        cycle();
        clear_inputs();
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL rename5_cnt: got %0d want 1", bus.busy_cnt); end
        drive_issue(5, 1, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_rdy !== 1'b0 || bus.op1_tag !== 5'd7 || bus.op1_data !== 32'h0) begin errors++; $display("FAIL busy_src: got rdy %0h tag %0h data %0h want 0/7/0", bus.op1_rdy, bus.op1_tag, bus.op1_data); end
        checks++; if (bus.op2_rdy !== 1'b1 || bus.op2_data !== 32'd1) begin errors++; $display("FAIL free_src: got rdy %0h data %0h want 1/1", bus.op2_rdy, bus.op2_data); end
        drive_cdb(1, 7, 32'h40);
        cycle();
        clear_inputs();
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL cdb5_cnt: got %0d want 0", bus.busy_cnt); end
        drive_issue(5, 0, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_rdy !== 1'b1 || bus.op1_data !== 32'h40) begin errors++; $display("FAIL cdb5_value: got rdy %0h data %0h want 1/40", bus.op1_rdy, bus.op1_data); end
    endtask

    task automatic test_stale_tag();
        drive_issue(0, 0, 1'b1, 4, 2);
        cycle();
        drive_issue(0, 0, 1'b1, 4, 9);
        cycle();
        clear_inputs();
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL rerename_cnt: got %0d want 1", bus.busy_cnt); end
        drive_cdb(0, 2, 32'hAA);
        cycle();
        clear_inputs();
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL stale_cnt: got %0d want 1", bus.busy_cnt); end
        drive_issue(4, 4, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_rdy !== 1'b0 || bus.op1_tag !== 5'd9) begin errors++; $display("FAIL stale_tag: got rdy %0h tag %0h want 0/9", bus.op1_rdy, bus.op1_tag); end
        drive_cdb(0, 9, 32'h99);
        cycle();
        clear_inputs();
        drive_issue(4, 0, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_data !== 32'h99 || bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL stale_final: got data %0h cnt %0d want 99/0", bus.op1_data, bus.busy_cnt); end
    endtask

    task automatic test_bypass();
        drive_issue(0, 0, 1'b1, 6, 3);
        cycle();
        clear_inputs();
        drive_issue(6, 6, 1'b0, 0, 0);
        drive_cdb(0, 3, 32'h55);
        cycle();
        clear_inputs();
`ifdef TOMASULO_REGSTAT_BYPASS_EN
        checks++; if (bus.op1_rdy !== 1'b1 || bus.op1_data !== 32'h55 || bus.op1_tag !== 5'h1f) begin errors++; $display("FAIL bypass_op1: got rdy %0h data %0h tag %0h want 1/55/1f", bus.op1_rdy, bus.op1_data, bus.op1_tag); end
`else
        checks++; if (bus.op1_rdy !== 1'b0 || bus.op1_tag !== 5'd3 || bus.op1_data !== 32'h0) begin errors++; $display("FAIL nobypass_op1: got rdy %0h data %0h tag %0h want 0/0/3", bus.op1_rdy, bus.op1_data, bus.op1_tag); end
`endif
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL bypass_cnt: got %0d want 0", bus.busy_cnt); end
        // Both ports carry the same tag: port 0 must win
        drive_issue(0, 0, 1'b1, 7, 10);
        cycle();
        clear_inputs();
        drive_cdb(0, 10, 32'h111);
        drive_cdb(1, 10, 32'h222);
        cycle();
        clear_inputs();
        drive_issue(6, 7, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_data !== 32'h55 || bus.op2_data !== 32'h111) begin errors++; $display("FAIL port_priority: got %0h/%0h want 55/111", bus.op1_data, bus.op2_data); end
    endtask

    task automatic test_rename_vs_cdb();
        drive_issue(0, 0, 1'b1, 8, 4);
        cycle();
        clear_inputs();
        drive_issue(9, 9, 1'b1, 8, 1);
        drive_cdb(0, 4, 32'h77);
        cycle();
        clear_inputs();
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL rename_wins_cnt: got %0d want 1", bus.busy_cnt); end
        drive_issue(8, 0, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_rdy !== 1'b0 || bus.op1_tag !== 5'd1) begin errors++; $display("FAIL rename_wins_tag: got rdy %0h tag %0h want 0/1", bus.op1_rdy, bus.op1_tag); end
        bus.flush = 1'b1;
        cycle();
        clear_inputs();
        drive_issue(8, 0, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_rdy !== 1'b1 || bus.op1_data !== 32'd8) begin errors++; $display("FAIL rename_wins_value: got rdy %0h data %0h want 1/8", bus.op1_rdy, bus.op1_data); end
    endtask

    task automatic test_flush();
        drive_issue(0, 0, 1'b1, 1, 11);
        cycle();
        drive_issue(0, 0, 1'b1, 2, 12);
        cycle();
        drive_issue(0, 0, 1'b1, 3, 13);
        cycle();
        clear_inputs();
        checks++; if (bus.busy_cnt !== 6'd3) begin errors++; $display("FAIL preflush_cnt: got %0d want 3", bus.busy_cnt); end
        bus.flush = 1'b1;
        drive_issue(1, 2, 1'b1, 9, 5);
        drive_cdb(0, 12, 32'h222);
        cycle();
        clear_inputs();
        checks++; if (bus.busy_cnt !== 6'd0 || bus.op_valid !== 1'b0) begin errors++; $display("FAIL flush: got cnt %0d op_valid %0h want 0/0", bus.busy_cnt, bus.op_valid); end
        drive_issue(1, 2, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_rdy !== 1'b1 || bus.op2_rdy !== 1'b1 || bus.op1_data !== 32'd1 || bus.op2_data !== 32'h222) begin errors++; $display("FAIL postflush_a: got %0h/%0h data %0h/%0h want 1/1 1/222", bus.op1_rdy, bus.op2_rdy, bus.op1_data, bus.op2_data); end
        drive_issue(3, 9, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op1_rdy !== 1'b1 || bus.op2_rdy !== 1'b1 || bus.op1_data !== 32'd3 || bus.op2_data !== 32'd9 || bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL postflush_b: got %0h/%0h data %0h/%0h cnt %0d want 1/1 3/9 0", bus.op1_rdy, bus.op2_rdy, bus.op1_data, bus.op2_data, bus.busy_cnt); end
    endtask

    task automatic test_back_to_back();
        drive_issue(5, 4, 1'b0, 0, 0);
        cycle();
        checks++; if (bus.op_valid !== 1'b1 || bus.op1_data !== 32'h40 || bus.op2_data !== 32'h99) begin errors++; $display("FAIL b2b_first: got v %0h data %0h/%0h want 1 40/99", bus.op_valid, bus.op1_data, bus.op2_data); end
        drive_issue(6, 7, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op_valid !== 1'b1 || bus.op1_data !== 32'h55 || bus.op2_data !== 32'h111) begin errors++; $display("FAIL b2b_second: got v %0h data %0h/%0h want 1 55/111", bus.op_valid, bus.op1_data, bus.op2_data); end
        cycle();
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0h want 0", bus.op_valid); end
    endtask

    task automatic test_async_reset();
        drive_issue(0, 0, 1'b1, 10, 3);
        cycle();
        checks++; if (bus.busy_cnt !== 6'd1 || bus.op_valid !== 1'b1) begin errors++; $display("FAIL prereset: got cnt %0d v %0h want 1/1", bus.busy_cnt, bus.op_valid); end
        clear_inputs();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy_cnt !== 6'd0 || bus.op_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got cnt %0d v %0h want 0/0", bus.busy_cnt, bus.op_valid); end
        rst = 1'b0;
        drive_issue(5, 10, 1'b0, 0, 0);
        cycle();
        clear_inputs();
        checks++; if (bus.op_valid !== 1'b1 || bus.op1_data !== 32'd5 || bus.op2_data !== 32'd10 || bus.op2_rdy !== 1'b1) begin errors++; $display("FAIL after_reset: got v %0h data %0h/%0h rdy2 %0h want 1 5/a 1", bus.op_valid, bus.op1_data, bus.op2_data, bus.op2_rdy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rename_cdb();
        test_stale_tag();
        test_bypass();
        test_rename_vs_cdb();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
